trap_sequencer: RTL



---
 rtl/trap_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// M-mode trap/mret sequencer: prioritises MEM-stage traps, writes mepc/mcause/mtval/mstatus
// one per cycle through the CSR write port, then redirects fetch to mtvec (or mepc on mret).
module trap_sequencer #(
    parameter bit MTVEC_VECTORED = 1'b0,
    parameter bit IRQ_EN         = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        illegal,
    input  logic        ecall,
    input  logic        l_fault,
    input  logic        s_fault,
    input  logic        mret,
    input  logic [31:0] epc,
    input  logic [31:0] tval_in,
    input  logic [31:0] mstatus,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        csr_w,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [1:0]  csr_wsc_mode,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_EPC   = 3'd1;
    localparam logic [2:0] S_W_CAUSE = 3'd2;
    localparam logic [2:0] S_W_TVAL  = 3'd3;
    localparam logic [2:0] S_W_STAT  = 3'd4;
    localparam logic [2:0] S_M_STAT  = 3'd5;
    localparam logic [2:0] S_REDIR   = 3'd6;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    logic [2:0]  state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] stat_q, stat_d;
    logic        is_mret_q, is_mret_d;

    logic        irq_take;
    logic        exc_any;
    logic        trap_req;
    logic [31:0] stat_trap;
    logic [31:0] stat_mret;
    logic [31:0] tvec_base;
    logic [31:0] tvec_off;
    logic        unused_mtvec_mode;

    assign unused_mtvec_mode = ^mtvec[1:0];

    assign irq_take = IRQ_EN && ext_irq && mstatus[3];
    assign exc_any  = illegal | ecall | l_fault | s_fault;
    assign trap_req = irq_take | exc_any;

    // Trap entry: MPP=M, MPIE<=MIE, MIE=0. mret: MIE<=MPIE, MPIE=1, MPP stays M.
    always_comb begin
        stat_trap        = stat_q;
        stat_trap[12:11] = 2'b11;
        stat_trap[7]     = stat_q[3];
        stat_trap[3]     = 1'b0;

        stat_mret        = stat_q;
        stat_mret[3]     = stat_q[7];
        stat_mret[7]     = 1'b1;
        stat_mret[12:11] = 2'b11;
    end

    assign tvec_base = {mtvec[31:2], 2'b00};
    assign tvec_off  = (MTVEC_VECTORED && cause_q[31]) ? {26'd0, cause_q[3:0], 2'b00} : 32'd0;

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        epc_d        = epc_q;
        tval_d       = tval_q;
        stat_d       = stat_q;
        is_mret_d    = is_mret_q;
        csr_w        = 1'b0;
        csr_waddr    = 12'd0;
        csr_wdata    = 32'd0;
        csr_wsc_mode = 2'b00;
        stall        = 1'b0;
        flush        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (trap_req) begin
                    stall     = 1'b1;
                    flush     = 1'b1;
                    epc_d     = epc;
                    stat_d    = mstatus;
                    is_mret_d = 1'b0;
                    state_d   = S_W_EPC;
                    if (irq_take) begin
                        cause_d = 32'h8000_000B;
                        tval_d  = 32'd0;
                    end else if (illegal) begin
                        cause_d = 32'd2;
                        tval_d  = tval_in;
                    end else if (ecall) begin
                        cause_d = 32'd11;
                        tval_d  = 32'd0;
                    end else if (l_fault) begin
                        cause_d = 32'd5;
                        tval_d  = tval_in;
                    end else begin
                        cause_d = 32'd7;
                        tval_d  = tval_in;
                    end
                end else if (mret) begin
                    stall     = 1'b1;
                    flush     = 1'b1;
                    stat_d    = mstatus;
                    is_mret_d = 1'b1;
                    state_d   = S_M_STAT;
                end
            end
            S_W_EPC: begin
                csr_w        = 1'b1;
                csr_wsc_mode = 2'b01;
                csr_waddr    = A_MEPC;
                csr_wdata    = epc_q;
                stall        = 1'b1;
                state_d      = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                csr_w        = 1'b1;
                csr_wsc_mode = 2'b01;
                csr_waddr    = A_MCAUSE;
                csr_wdata    = cause_q;
                stall        = 1'b1;
                state_d      = S_W_TVAL;
            end
            S_W_TVAL: begin
                csr_w        = 1'b1;
                csr_wsc_mode = 2'b01;
                csr_waddr    = A_MTVAL;
                csr_wdata    = tval_q;
                stall        = 1'b1;
                state_d      = S_W_STAT;
            end
            S_W_STAT: begin
                csr_w        = 1'b1;
                csr_wsc_mode = 2'b01;
                csr_waddr    = A_MSTATUS;
                csr_wdata    = stat_trap;
                stall        = 1'b1;
                state_d      = S_REDIR;
            end
            S_M_STAT: begin
                csr_w        = 1'b1;
                csr_wsc_mode = 2'b01;
                csr_waddr    = A_MSTATUS;
                csr_wdata    = stat_mret;
                stall        = 1'b1;
                state_d      = S_REDIR;
            end
            S_REDIR: begin
                stall       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = is_mret_q ? mepc : (tvec_base + tvec_off);
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
            tval_q    <= 32'd0;
            stat_q    <= 32'd0;
            is_mret_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            tval_q    <= tval_d;
            stat_q    <= stat_d;
            is_mret_q <= is_mret_d;
        end
    end

endmodule
